y_sobel: RTL and testbench
==========================

# y_sobel

Streaming 3x3 Sobel edge detector on the 8-bit luma stream. Sits directly downstream of the RGB-to-luma converter and consumes its luma, dv/hs/vs and line-end outputs. Buffers two previous lines in on-chip RAM, forms a 3x3 window, and emits a saturated gradient magnitude per pixel. The sync signals are delayed to stay aligned with the magnitude.

## Interface
Parameters:
- MAX_WIDTH, 1920: line-buffer depth; maximum active pixels per line.
- AW, $clog2(MAX_WIDTH): column counter / RAM address width.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (low = reset).
- y_i  in  8  luma pixel; valid when dv_i=1.
- dv_i  in  1  data valid.
- hs_i  in  1  hsync.
- vs_i  in  1  vsync.
- line_end_i  in  1  one-cycle pulse after the last valid pixel of a line.
- thresh_i  in  8  binarisation threshold; used only with SOBEL_BINARY_EN.
- edge_o  out  8  edge magnitude.
- dv_o  out  1  dv_i delayed by 4 cycles.
- hs_o  out  1  hs_i delayed by 4 cycles.
- vs_o  out  1  vs_i delayed by 4 cycles.

## Operation
- **Column counter x (AW bits):**
  - Increments on each dv_i=1 cycle.
  - Clears on line_end_i, or on a dv_i 1->0 transition, whichever comes first. Both in the same cycle clear once.
  - Saturates at MAX_WIDTH.
- **Row counter r (2 bits):**
  - Increments on each line_end_i.
  - Saturates at 2.
  - Clears on the vs_i rising edge, detected against a registered copy of vs_i.
- **Line buffers lb0 and lb1:** MAX_WIDTH x 8 each, 1-cycle synchronous read, read-before-write at address x.
  - On dv_i=1 with x<MAX_WIDTH: read lb0[x] and lb1[x], write lb0[x]<=y_i, and write lb1[x]<=old lb0[x].
  - Pixels with x>=MAX_WIDTH are not written. Their output is 0.
- **Window:** three 3-tap shift registers, columns k-2..k.
  - Top row from lb1, middle row from lb0, bottom row from the current pixel.
  - Shifts only on valid pixels.
- **Arithmetic** (window p[row][col], row 0 = oldest line, col 0 = oldest column):
  - Gx = (p02+2p12+p22) - (p00+2p10+p20). Signed 11 bits.
  - Gy = (p20+2p21+p22) - (p00+2p01+p02). Signed 11 bits.
  - mag = |Gx|+|Gy|. Unsigned 12 bits, max 2040.
  - edge = min(mag, 255).
- **Mapping:** output pixel k of line n is centred at (n-1, k-1). It is forced to 0 when r<2 or k<2 (border).
- **Invalid cycles:** when dv_o=0, edge_o=0.
- **Reset:**
  - Counters and the window are cleared.
  - The pipeline is flushed; edge_o, dv_o, hs_o and vs_o all read 0.
  - Line buffer RAM is not cleared. Stale data is masked by r<2.

## Timing
- Fixed 4-cycle latency from input to output, with edge_o aligned to dv_o:
  - Stage 1: RAM read and border-flag capture.
  - Stage 2: window shift.
  - Stage 3: Gx/Gy.
  - Stage 4: abs, sum and saturate into the registered edge_o.
- Sync delay lines are 4-deep shift registers, reset to 0.
- No backpressure. The block accepts one pixel per cycle, every cycle.
- Reset asserted mid-line:
  - Outputs are 0 from the first clock edge with rst=0.
  - The first frame after reset starts from r=0.
- A vs_i rising edge mid-line is honoured immediately: r=0, so all subsequent outputs are 0 until two line_end_i pulses have been seen.

## Configuration
- SOBEL_BINARY_EN defined: edge_o = 255 when saturated mag > thresh_i, else 0. Border and dv masking are still applied. Latency is unchanged (the compare folds into stage 4).
- SOBEL_BINARY_EN undefined: edge_o is the saturated magnitude. thresh_i is ignored.

## Test plan
- **Flat frame:** 16x8 frame, all y=100 -> edge_o=0 on every dv_o cycle; dv_o/hs_o/vs_o equal the inputs delayed by exactly 4 cycles.
- **Vertical step:** 16x8, y=0 for x<8, y=255 for x>=8 -> in lines n>=2, edge_o=255 at output pixels 8 and 9, 0 elsewhere; lines 0-1 all 0.
- **Horizontal ramp:** y_i=x, 16x8 -> edge_o=8 for k>=2 in lines n>=2; 0 at k<2.
- **Reset mid-frame:** drive the ramp, pull rst low for 1 cycle during line 4 -> outputs 0 for 4 cycles. Continuing lines give 0 until two line_end_i pulses after reset, then 8.
- **Overlong line:** MAX_WIDTH=16, drive a 20-pixel ramp line -> edge_o=0 for k>=16; lines remain correctly aligned afterwards.
- **SOBEL_BINARY_EN build, thresh_i=100:** ramp -> all 0; vertical step -> 255 at pixels 8 and 9 only.

Source files
------------

// File: rtl/y_sobel.sv
// y_sobel: streaming 3x3 Sobel gradient magnitude on 8-bit luma, two line buffers, fixed 4-cycle latency.
// Define SOBEL_BINARY_EN to output 255/0 by comparing the saturated magnitude against thresh_i.
module y_sobel #(
    parameter int MAX_WIDTH = 1920,
    parameter int AW        = $clog2(MAX_WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] y_i,
    input  logic       dv_i,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic       line_end_i,
    input  logic [7:0] thresh_i,
    output logic [7:0] edge_o,
    output logic       dv_o,
    output logic       hs_o,
    output logic       vs_o
);
    // One extra bit so the column counter can actually hold MAX_WIDTH when it is a power of two
    localparam logic [AW:0] XMAX = (AW+1)'(MAX_WIDTH);

    logic [AW:0]   x_q, x_d;
    logic [AW-1:0] addr;
    logic [1:0]    r_q, r_d;
    logic          dv_q, vs_q, vs_rise, in_rng, ram_en, ok_d;
    logic [7:0]    lb0_q [MAX_WIDTH];
    logic [7:0]    lb1_q [MAX_WIDTH];
    logic [7:0]    top_q, mid_q, bot_q;
    logic          ok1_q, ok2_q, ok3_q;
    logic [3:0]    dv_sr_q, hs_sr_q, vs_sr_q;
    logic [7:0]    w_q [3][3];
    logic [10:0]   gx_d, gy_d, gx_q, gy_q, ax, ay;
    logic [11:0]   mag;
    logic [7:0]    sat, edge_d, edge_q;

    always_comb begin
        vs_rise = vs_i && !vs_q;
        in_rng  = x_q < XMAX;
        addr    = x_q[AW-1:0];
        ram_en  = rst && dv_i && in_rng;
        x_d     = (line_end_i || (dv_q && !dv_i)) ? '0 : (dv_i && in_rng) ? x_q + 1'b1 : x_q;
        r_d     = vs_rise ? 2'd0 : (line_end_i && r_q != 2'd2) ? r_q + 2'd1 : r_q;
        ok_d    = dv_i && !vs_rise && r_q == 2'd2 && |x_q[AW:1] && in_rng;
        gx_d    = ({3'b0, w_q[0][2]} + {2'b0, w_q[1][2], 1'b0} + {3'b0, w_q[2][2]})
                - ({3'b0, w_q[0][0]} + {2'b0, w_q[1][0], 1'b0} + {3'b0, w_q[2][0]});
        gy_d    = ({3'b0, w_q[2][0]} + {2'b0, w_q[2][1], 1'b0} + {3'b0, w_q[2][2]})
                - ({3'b0, w_q[0][0]} + {2'b0, w_q[0][1], 1'b0} + {3'b0, w_q[0][2]});
        ax      = gx_q[10] ? -gx_q : gx_q;
        ay      = gy_q[10] ? -gy_q : gy_q;
        mag     = {1'b0, ax} + {1'b0, ay};
        sat     = |mag[11:8] ? 8'hFF : mag[7:0];
`ifdef SOBEL_BINARY_EN
        edge_d  = (ok3_q && sat > thresh_i) ? 8'hFF : 8'h00;
`else
        edge_d  = ok3_q ? sat : 8'h00;
`endif
    end

`ifndef SOBEL_BINARY_EN
    logic unused_thresh;
    assign unused_thresh = &{1'b0, thresh_i};
`endif

    // Read-before-write: lb1 takes the old lb0 word, so it always holds the line two back
    always_ff @(posedge clk) begin
        if (ram_en) begin
            top_q       <= lb1_q[addr];
            mid_q       <= lb0_q[addr];
            lb1_q[addr] <= lb0_q[addr];
            lb0_q[addr] <= y_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q     <= '0;
            r_q     <= '0;
            dv_q    <= 1'b0;
            vs_q    <= 1'b0;
            bot_q   <= '0;
            ok1_q   <= 1'b0;
            ok2_q   <= 1'b0;
            ok3_q   <= 1'b0;
            dv_sr_q <= '0;
            hs_sr_q <= '0;
            vs_sr_q <= '0;
            w_q     <= '{default: '0};
            gx_q    <= '0;
            gy_q    <= '0;
            edge_q  <= '0;
        end else begin
            x_q     <= x_d;
            r_q     <= r_d;
            dv_q    <= dv_i;
            vs_q    <= vs_i;
            bot_q   <= y_i;
            ok1_q   <= ok_d;
            ok2_q   <= ok1_q;
            ok3_q   <= ok2_q;
            dv_sr_q <= {dv_sr_q[2:0], dv_i};
            hs_sr_q <= {hs_sr_q[2:0], hs_i};
            vs_sr_q <= {vs_sr_q[2:0], vs_i};
            if (dv_sr_q[0]) begin
                w_q[0] <= '{w_q[0][1], w_q[0][2], top_q};
                w_q[1] <= '{w_q[1][1], w_q[1][2], mid_q};
                w_q[2] <= '{w_q[2][1], w_q[2][2], bot_q};
            end
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            edge_q  <= edge_d;
        end
    end

    assign edge_o = edge_q;
    assign dv_o   = dv_sr_q[3];
    assign hs_o   = hs_sr_q[3];
    assign vs_o   = vs_sr_q[3];
endmodule

// File: tb/tb_y_sobel.sv
// tb_y_sobel: randomized and directed frames against a per-line column model of the Sobel stream.
module tb_y_sobel;
    localparam int MW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] y_i = '0, thresh_i = 8'd100;
    logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0, line_end_i = 1'b0;
    logic [7:0] edge_o;
    logic       dv_o, hs_o, vs_o;

    always #5 clk = ~clk;

    y_sobel #(.MAX_WIDTH(MW)) dut (
        .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .line_end_i(line_end_i), .thresh_i(thresh_i),
        .edge_o(edge_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    typedef struct packed {
        logic [7:0] e;
        logic       dv;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t       pipe_q[$];
    int         checks = 0, errors = 0, n8 = 0, n255 = 0;
    int         mx = 0, mr = 0;
    bit         mdv_prev = 0, mvs_prev = 0;
    logic [7:0] mlb0 [MW];
    logic [7:0] mlb1 [MW];
    int         ct [MW];
    int         cm [MW];
    int         cb [MW];

    // Window for column k is built from what each row delivered at columns k-2..k of this line
    function automatic logic [7:0] sobel(int k);
        int gx, gy, m;
        gx = ct[k] + 2*cm[k] + cb[k] - ct[k-2] - 2*cm[k-2] - cb[k-2];
        gy = cb[k-2] + 2*cb[k-1] + cb[k] - ct[k-2] - 2*ct[k-1] - ct[k];
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_BINARY_EN
        return (m > int'(thresh_i)) ? 8'd255 : 8'd0;
`else
        return 8'(m);
`endif
    endfunction

    function automatic logic [7:0] pix(int mode, int k);
        case (mode)
            0:       return 8'd100;
            1:       return (k < 8) ? 8'd0 : 8'd255;
            2:       return 8'(k);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, got, want);
        end
    endtask

    task automatic step(input logic [7:0] y, input logic dv, input logic hs,
                        input logic vs, input logic le, input logic rv);
        exp_t e, x;
        bit   vr, clr;
        int   rn;
        y_i = y; dv_i = dv; hs_i = hs; vs_i = vs; line_end_i = le; rst = rv;
        @(posedge clk);
        if (!rv) begin
            mx = 0; mr = 0; mdv_prev = 0; mvs_prev = 0;
            pipe_q.delete();
            repeat (4) pipe_q.push_back('0);
        end else begin
            vr = vs && !mvs_prev;
            rn = vr ? 0 : mr;
            e  = '{e: 8'd0, dv: dv, hs: hs, vs: vs};
            if (dv && mx < MW) begin
                ct[mx] = int'(mlb1[mx]); cm[mx] = int'(mlb0[mx]); cb[mx] = int'(y);
                mlb1[mx] = mlb0[mx];
                mlb0[mx] = y;
                if (rn == 2 && mx >= 2) e.e = sobel(mx);
            end
            clr = le || (mdv_prev && !dv);
            mx  = clr ? 0 : (dv && mx < MW) ? mx + 1 : mx;
            mr  = vr ? 0 : (le && mr < 2) ? mr + 1 : mr;
            mdv_prev = dv;
            mvs_prev = vs;
            pipe_q.push_back(e);
            void'(pipe_q.pop_front());
        end
        x = pipe_q[0];
        #1;
        chk("edge_o", edge_o, x.e);
        chk("dv_o", {7'd0, dv_o}, {7'd0, x.dv});
        chk("hs_o", {7'd0, hs_o}, {7'd0, x.hs});
        chk("vs_o", {7'd0, vs_o}, {7'd0, x.vs});
        if (dv_o === 1'b1 && edge_o === 8'd8) n8++;
        if (dv_o === 1'b1 && edge_o === 8'd255) n255++;
    endtask

    // 8-line frame; optional 1-cycle reset, one 20-pixel line, and a vs pulse inside a line
    task automatic frame(input int mode, input int rst_line, input int rst_px,
                         input int long_line, input int vs_line, input int vs_px);
        int len;
        bit rv, vv;
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        for (int n = 0; n < 8; n++) begin
            len = (n == long_line) ? 20 : MW;
            for (int k = 0; k < len; k++) begin
                rv = !(n == rst_line && k == rst_px);
                vv = (n == vs_line && (k == vs_px || k == vs_px + 1));
                step(pix(mode, k), rv, 0, vv, 0, rv);
            end
            step(0, 0, 0, 0, 1, 1);
            step(0, 0, 1, 0, 0, 1);
            step(0, 0, 1, 0, 0, 1);
            step(0, 0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) begin
            mlb0[i] = '0; mlb1[i] = '0; ct[i] = 0; cm[i] = 0; cb[i] = 0;
        end
        repeat (4) pipe_q.push_back('0);
        repeat (3) step(8'd55, 1, 1, 1, 0, 0);
        frame(0, -1, 0, -1, -1, 0);
        n255 = 0;
        frame(1, -1, 0, -1, -1, 0);
        checks++;
        assert (n255 == 12) else begin
            errors++;
            $error("FAIL step_count observed=%0d expected=%0d", n255, 12);
        end
        n8 = 0;
        frame(2, -1, 0, -1, -1, 0);
        checks++;
`ifdef SOBEL_BINARY_EN
        assert (n8 == 0) else begin
            errors++;
            $error("FAIL ramp_count observed=%0d expected=%0d", n8, 0);
        end
`else
        assert (n8 == 84) else begin
            errors++;
            $error("FAIL ramp_count observed=%0d expected=%0d", n8, 84);
        end
`endif
        frame(3, -1, 0, -1, 3, 5);
        frame(2, 4, 6, -1, -1, 0);
        frame(2, -1, 0, 3, -1, 0);
        frame(3, -1, 0, 5, -1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
